// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: owns the PC, fetches words ahead of the decoder into a
// small FIFO, and hands the head word out as an instruction or as a shiftable imm16.
module inst_prefetch_queue #(
  parameter int unsigned NSHIFT   = 2,
  parameter int unsigned REG_BITS = 8,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  output logic                                  fetch_req,
  output logic [2*REG_BITS-1:0]                 fetch_addr,
  input  logic                                  fetch_ack,
  input  logic                                  fetch_data_valid,
  input  logic [2*REG_BITS-1:0]                 fetch_data,
  output logic                                  inst_valid,
  output logic [2*REG_BITS-1:0]                 inst,
  input  logic                                  inst_done,
  input  logic                                  load_imm16,
  output logic                                  imm16_loaded,
  output logic [2*REG_BITS-1:0]                 imm_full,
  output logic [NSHIFT-1:0]                     imm_data_in,
  input  logic                                  next_imm_data,
  input  logic                                  block_prefetch,
  input  logic                                  write_pc,
  input  logic                                  ext_pc_next,
  input  logic [$clog2(2*REG_BITS/NSHIFT)-1:0]  comp_counter,
  input  logic [NSHIFT-1:0]                     pc_data_out,
  output logic [NSHIFT-1:0]                     pc_data_in,
  output logic                                  prefetch_idle
);
  localparam int unsigned W      = 2 * REG_BITS;
  localparam int unsigned NCHUNK = W / NSHIFT;
  localparam int unsigned CW     = $clog2(NCHUNK);
  localparam int unsigned PW     = $clog2(QDEPTH);
  localparam int unsigned CNTW   = $clog2(QDEPTH + 1);

  logic [W-1:0]    pc;
  logic [W-1:0]    fetch_pc;
  logic [W-1:0]    pc_shadow;
  logic [W-1:0]    imm;
  logic [W-1:0]    mem [QDEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CNTW-1:0] count;
  logic            outstanding;
  logic            discard;
  logic            imm_valid;

  logic            flush_now;
  logic            not_empty;
  logic            fire;
  logic            resp;
  logic            push;
  logic            pop;
  logic            advance;
  logic            imm_capture;
  logic            capture;
  logic            pop_inst;
  logic            ext_step;
  logic [W-1:0]    shadow_next;
  logic [W-1:0]    new_pc;

  // Handshake, consume and flush decisions for this cycle
  always_comb begin
    flush_now     = write_pc && (comp_counter == CW'(NCHUNK - 1));
    not_empty     = (count != '0);
    fetch_req     = !reset && !block_prefetch && !outstanding &&
                    (count < CNTW'(QDEPTH)) && !flush_now;
    fire          = fetch_req && fetch_ack;
    resp          = fetch_data_valid && outstanding;
    push          = resp && !discard && !flush_now;
    imm_capture   = load_imm16 && !imm_valid;
    inst_valid    = not_empty && !imm_capture;
    capture       = imm_capture && not_empty;
    pop_inst      = inst_done && inst_valid;
    prefetch_idle = !outstanding && !fetch_req;
    ext_step      = ext_pc_next && prefetch_idle;
    pop           = capture || pop_inst || (ext_step && not_empty);
    advance       = capture || pop_inst || ext_step;
    shadow_next   = pc_shadow;
    if (write_pc) shadow_next[int'(comp_counter)*NSHIFT +: NSHIFT] = pc_data_out;
    new_pc        = {shadow_next[W-1:1], 1'b0};
  end

  assign fetch_addr   = fetch_pc;
  assign inst         = mem[rd_ptr];
  assign imm16_loaded = imm_valid;
  assign imm_full     = imm;
  assign imm_data_in  = imm[NSHIFT-1:0];
  assign pc_data_in   = pc[int'(comp_counter)*NSHIFT +: NSHIFT];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fetch_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      fetch_pc    <= '0;
      pc_shadow   <= '0;
      imm         <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      imm_valid   <= 1'b0;
    end else begin
      pc_shadow <= shadow_next;

      if (fire)      outstanding <= 1'b1;
      else if (resp) outstanding <= 1'b0;

      if (capture)            imm <= inst;
      else if (next_imm_data) imm <= imm >> NSHIFT;

      if (flush_now) begin
        pc        <= new_pc;
        fetch_pc  <= new_pc;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
        imm_valid <= 1'b0;
        // A response still in flight belongs to the old stream and must be dropped
        discard   <= (outstanding && !fetch_data_valid) || fire;
      end else begin
        if (advance) pc <= pc + W'(2);
        if (fire)    fetch_pc <= fetch_pc + W'(2);
        if (push)    wr_ptr <= wr_ptr + PW'(1);
        if (pop)     rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CNTW'(1);
          2'b01:   count <= count - CNTW'(1);
          default: count <= count;
        endcase
        if (capture)        imm_valid <= 1'b1;
        else if (inst_done) imm_valid <= 1'b0;
        if (resp) discard <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed scenarios followed by a randomized run
// against a queue-based reference model with a variable-latency memory responder.
module tb_inst_prefetch_queue;
  localparam int unsigned NSHIFT   = 2;
  localparam int unsigned REG_BITS = 8;
  localparam int unsigned QDEPTH   = 2;
  localparam int unsigned CW       = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic        fetch_data_valid;
  logic [15:0] fetch_data;
  logic        inst_valid;
  logic [15:0] inst;
  logic        inst_done;
  logic        load_imm16;
  logic        imm16_loaded;
  logic [15:0] imm_full;
  logic [1:0]  imm_data_in;
  logic        next_imm_data;
  logic        block_prefetch;
  logic        write_pc;
  logic        ext_pc_next;
  logic [CW-1:0] comp_counter;
  logic [1:0]  pc_data_out;
  logic [1:0]  pc_data_in;
  logic        prefetch_idle;

  int n_checks = 0;
  int n_fail   = 0;

  inst_prefetch_queue #(.NSHIFT(NSHIFT), .REG_BITS(REG_BITS), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .fetch_data_valid(fetch_data_valid), .fetch_data(fetch_data),
    .inst_valid(inst_valid), .inst(inst), .inst_done(inst_done),
    .load_imm16(load_imm16), .imm16_loaded(imm16_loaded), .imm_full(imm_full),
    .imm_data_in(imm_data_in), .next_imm_data(next_imm_data),
    .block_prefetch(block_prefetch), .write_pc(write_pc), .ext_pc_next(ext_pc_next),
    .comp_counter(comp_counter), .pc_data_out(pc_data_out), .pc_data_in(pc_data_in),
    .prefetch_idle(prefetch_idle)
  );

  always #10 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; fetch_ack = 1'b0; fetch_data_valid = 1'b0; fetch_data = '0;
    inst_done = 1'b0; load_imm16 = 1'b0; next_imm_data = 1'b0; block_prefetch = 1'b0;
    write_pc = 1'b0; ext_pc_next = 1'b0; comp_counter = '0; pc_data_out = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  // Accept the pending request and return one word on the following cycle
  task automatic fetch_one(input logic [15:0] data);
    fetch_ack = 1'b1;
    cycle();
    fetch_ack = 1'b0;
    fetch_data_valid = 1'b1;
    fetch_data = data;
    cycle();
    fetch_data_valid = 1'b0;
  endtask

  task automatic pulse_inst_done();
    inst_done = 1'b1;
    cycle();
    inst_done = 1'b0;
  endtask

  task automatic write_pc_value(input logic [15:0] v);
    for (int i = 0; i < 8; i++) begin
      write_pc = 1'b1;
      comp_counter = CW'(i);
      pc_data_out = v[2*i +: 2];
      cycle();
    end
    write_pc = 1'b0;
  endtask

  task automatic read_pc(output logic [15:0] v);
    v = '0;
    for (int i = 0; i < 8; i++) begin
      comp_counter = CW'(i);
      #1;
      v[2*i +: 2] = pc_data_in;
    end
  endtask

  task automatic test_reset();
    logic [15:0] pcv;
    clear_inputs();
    reset = 1'b1;
    cycle();
    settle();
    n_checks++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_req: got %0h want 0", fetch_req); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %0h want 0", inst_valid); end
    n_checks++; if (imm16_loaded !== 1'b0) begin n_fail++; $display("FAIL reset_imm16_loaded: got %0h want 0", imm16_loaded); end
    n_checks++; if (prefetch_idle !== 1'b1) begin n_fail++; $display("FAIL reset_prefetch_idle: got %0h want 1", prefetch_idle); end
    n_checks++; if (fetch_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_fetch_addr: got %04h want 0000", fetch_addr); end
    n_checks++; if (imm_full !== 16'h0000) begin n_fail++; $display("FAIL reset_imm_full: got %04h want 0000", imm_full); end
    cycle();
    reset = 1'b0;
    read_pc(pcv);
    n_checks++; if (pcv !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %04h want 0000", pcv); end
    n_checks++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL reset_release_req: got %0h want 1", fetch_req); end
  endtask

  task automatic test_fetch_fill();
    logic [15:0] pcv;
    apply_reset();
    settle();
    n_checks++; if (fetch_addr !== 16'h0000) begin n_fail++; $display("FAIL fill_addr0: got %04h want 0000", fetch_addr); end
    fetch_one(16'h8123);
    settle();
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL fill_inst_valid: got %0h want 1", inst_valid); end
    n_checks++; if (inst !== 16'h8123) begin n_fail++; $display("FAIL fill_inst: got %04h want 8123", inst); end
    n_checks++; if (fetch_addr !== 16'h0002) begin n_fail++; $display("FAIL fill_addr2: got %04h want 0002", fetch_addr); end
    fetch_one(16'h4567);
    settle();
    n_checks++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL fill_full_req: got %0h want 0", fetch_req); end
    n_checks++; if (prefetch_idle !== 1'b1) begin n_fail++; $display("FAIL fill_full_idle: got %0h want 1", prefetch_idle); end
    n_checks++; if (inst !== 16'h8123) begin n_fail++; $display("FAIL fill_head_kept: got %04h want 8123", inst); end
    pulse_inst_done();
    settle();
    n_checks++; if (inst !== 16'h4567) begin n_fail++; $display("FAIL fill_next_head: got %04h want 4567", inst); end
    n_checks++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL fill_resume_req: got %0h want 1", fetch_req); end
    n_checks++; if (fetch_addr !== 16'h0004) begin n_fail++; $display("FAIL fill_addr4: got %04h want 0004", fetch_addr); end
    read_pc(pcv);
    n_checks++; if (pcv !== 16'h0002) begin n_fail++; $display("FAIL fill_pc: got %04h want 0002", pcv); end
  endtask

  task automatic test_imm();
    logic [1:0]  exp_steps [5];
    logic [15:0] pcv;
    exp_steps = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd2};
    apply_reset();
    fetch_one(16'h1234);
    load_imm16 = 1'b1;
    settle();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL imm_capture_hides_inst: got %0h want 0", inst_valid); end
    cycle();
    load_imm16 = 1'b0;
    settle();
    n_checks++; if (imm16_loaded !== 1'b1) begin n_fail++; $display("FAIL imm_loaded: got %0h want 1", imm16_loaded); end
    n_checks++; if (imm_full !== 16'h1234) begin n_fail++; $display("FAIL imm_full: got %04h want 1234", imm_full); end
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (imm_data_in !== exp_steps[k]) begin n_fail++; $display("FAIL imm_step%0d: got %0d want %0d", k, imm_data_in, exp_steps[k]); end
      next_imm_data = 1'b1;
      cycle();
      next_imm_data = 1'b0;
      settle();
    end
    n_checks++; if (imm_full !== 16'h0004) begin n_fail++; $display("FAIL imm_shifted: got %04h want 0004", imm_full); end
    pulse_inst_done();
    settle();
    n_checks++; if (imm16_loaded !== 1'b0) begin n_fail++; $display("FAIL imm_cleared: got %0h want 0", imm16_loaded); end
    read_pc(pcv);
    n_checks++; if (pcv !== 16'h0002) begin n_fail++; $display("FAIL imm_pc: got %04h want 0002", pcv); end
  endtask

  task automatic test_pc_flush();
    logic [15:0] target;
    logic [15:0] pcv;
    target = 16'hABCC;
    apply_reset();
    fetch_one(16'h1111);
    fetch_one(16'h2222);
    pulse_inst_done();
    fetch_one(16'h3333);
    pulse_inst_done();
    settle();
    n_checks++; if (fetch_addr !== 16'h0006) begin n_fail++; $display("FAIL flush_addr6: got %04h want 0006", fetch_addr); end
    fetch_ack = 1'b1;
    cycle();
    fetch_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      write_pc = 1'b1;
      comp_counter = CW'(i);
      pc_data_out = target[2*i +: 2];
      settle();
      if (i == 1) begin
        n_checks++; if (pc_data_in !== 2'd1) begin n_fail++; $display("FAIL flush_read_live_pc: got %0d want 1", pc_data_in); end
      end
      cycle();
    end
    write_pc = 1'b0;
    settle();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_fifo_empty: got %0h want 0", inst_valid); end
    n_checks++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL flush_wait_stale: got %0h want 0", fetch_req); end
    fetch_data_valid = 1'b1;
    fetch_data = 16'hDEAD;
    cycle();
    fetch_data_valid = 1'b0;
    settle();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale_dropped: got %0h want 0", inst_valid); end
    n_checks++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL flush_refetch_req: got %0h want 1", fetch_req); end
    n_checks++; if (fetch_addr !== 16'hABCC) begin n_fail++; $display("FAIL flush_new_addr: got %04h want abcc", fetch_addr); end
    read_pc(pcv);
    n_checks++; if (pcv !== 16'hABCC) begin n_fail++; $display("FAIL flush_pc: got %04h want abcc", pcv); end
    fetch_one(16'h7777);
    settle();
    n_checks++; if (inst !== 16'h7777 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL flush_first_word: got %04h/%0h want 7777/1", inst, inst_valid); end
  endtask

  task automatic test_block_ext();
    logic [15:0] pcv;
    apply_reset();
    block_prefetch = 1'b1;
    write_pc_value(16'h0010);
    settle();
    n_checks++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL block_req: got %0h want 0", fetch_req); end
    n_checks++; if (prefetch_idle !== 1'b1) begin n_fail++; $display("FAIL block_idle: got %0h want 1", prefetch_idle); end
    read_pc(pcv);
    n_checks++; if (pcv !== 16'h0010) begin n_fail++; $display("FAIL block_pc_before: got %04h want 0010", pcv); end
    ext_pc_next = 1'b1;
    cycle();
    ext_pc_next = 1'b0;
    read_pc(pcv);
    n_checks++; if (pcv !== 16'h0012) begin n_fail++; $display("FAIL ext_pc_after: got %04h want 0012", pcv); end
    n_checks++; if (fetch_addr !== 16'h0010) begin n_fail++; $display("FAIL ext_fetch_addr: got %04h want 0010", fetch_addr); end
  endtask

  task automatic test_wrap();
    logic [15:0] pcv;
    apply_reset();
    block_prefetch = 1'b1;
    write_pc_value(16'hFFFE);
    block_prefetch = 1'b0;
    settle();
    n_checks++; if (fetch_addr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_addr_top: got %04h want fffe", fetch_addr); end
    fetch_one(16'h5555);
    settle();
    n_checks++; if (fetch_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr_zero: got %04h want 0000", fetch_addr); end
    n_checks++; if (inst !== 16'h5555) begin n_fail++; $display("FAIL wrap_inst: got %04h want 5555", inst); end
    pulse_inst_done();
    read_pc(pcv);
    n_checks++; if (pcv !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc: got %04h want 0000", pcv); end
  endtask

  task automatic test_reset_stale();
    apply_reset();
    fetch_ack = 1'b1;
    cycle();
    fetch_ack = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    block_prefetch = 1'b1;
    fetch_data_valid = 1'b1;
    fetch_data = 16'hBEEF;
    cycle();
    fetch_data_valid = 1'b0;
    settle();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stale_inst_valid: got %0h want 0", inst_valid); end
    n_checks++; if (prefetch_idle !== 1'b1) begin n_fail++; $display("FAIL stale_idle: got %0h want 1", prefetch_idle); end
    block_prefetch = 1'b0;
    settle();
    n_checks++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0000) begin n_fail++; $display("FAIL stale_refetch: got %0h@%04h want 1@0000", fetch_req, fetch_addr); end
  endtask

  task automatic test_random();
    logic [15:0] m_pc, m_fpc, m_shadow, m_imm, resp_addr, wr_target;
    logic        m_out, m_disc, m_immv;
    logic [15:0] m_q [$];
    logic        e_req, e_ivalid, e_idle, flush, fire, resp, cap, popi, ext;
    logic [1:0]  e_pcd;
    int          resp_timer, wr_idx, ci;
    apply_reset();
    m_pc = '0; m_fpc = '0; m_shadow = '0; m_imm = '0;
    m_out = 1'b0; m_disc = 1'b0; m_immv = 1'b0; m_q.delete();
    resp_timer = 0; wr_idx = -1; resp_addr = '0; wr_target = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      clear_inputs();
      block_prefetch = ($urandom_range(0, 9) < 2);
      fetch_ack = ($urandom_range(0, 1) == 1);
      if (resp_timer > 0) begin
        resp_timer--;
        if (resp_timer == 0) begin
          fetch_data_valid = 1'b1;
          fetch_data = mem_word(resp_addr);
        end
      end
      if (wr_idx < 0 && $urandom_range(0, 39) == 0) begin
        wr_idx = 0;
        wr_target = 16'($urandom) & 16'hFFFE;
      end
      if (wr_idx >= 0) begin
        write_pc = 1'b1;
        comp_counter = CW'(wr_idx);
        pc_data_out = wr_target[2*wr_idx +: 2];
      end else begin
        comp_counter = CW'($urandom_range(0, 7));
      end
      load_imm16 = ($urandom_range(0, 5) == 0);
      next_imm_data = m_immv && ($urandom_range(0, 1) == 1);
      e_ivalid = (m_q.size() != 0) && !(load_imm16 && !m_immv);
      inst_done = (e_ivalid || m_immv) && ($urandom_range(0, 2) == 0);
      ext_pc_next = !inst_done && !load_imm16 && ($urandom_range(0, 7) == 0);
      flush = write_pc && (wr_idx == 7);
      e_req = !block_prefetch && !m_out && (m_q.size() < int'(QDEPTH)) && !flush;
      e_idle = !m_out && !e_req;
      ci = int'(comp_counter);
      e_pcd = 2'((m_pc >> (2 * ci)));
      settle();
      n_checks++; if (fetch_req !== e_req) begin n_fail++; $display("FAIL rnd_fetch_req c%0d: got %0h want %0h", cyc, fetch_req, e_req); end
      n_checks++; if (fetch_addr !== m_fpc) begin n_fail++; $display("FAIL rnd_fetch_addr c%0d: got %04h want %04h", cyc, fetch_addr, m_fpc); end
      n_checks++; if (inst_valid !== e_ivalid) begin n_fail++; $display("FAIL rnd_inst_valid c%0d: got %0h want %0h", cyc, inst_valid, e_ivalid); end
      if (e_ivalid) begin
        n_checks++; if (inst !== m_q[0]) begin n_fail++; $display("FAIL rnd_inst c%0d: got %04h want %04h", cyc, inst, m_q[0]); end
      end
      n_checks++; if (imm16_loaded !== m_immv) begin n_fail++; $display("FAIL rnd_imm16_loaded c%0d: got %0h want %0h", cyc, imm16_loaded, m_immv); end
      n_checks++; if (imm_full !== m_imm) begin n_fail++; $display("FAIL rnd_imm_full c%0d: got %04h want %04h", cyc, imm_full, m_imm); end
      n_checks++; if (imm_data_in !== m_imm[1:0]) begin n_fail++; $display("FAIL rnd_imm_data_in c%0d: got %0d want %0d", cyc, imm_data_in, m_imm[1:0]); end
      n_checks++; if (pc_data_in !== e_pcd) begin n_fail++; $display("FAIL rnd_pc_data_in c%0d: got %0d want %0d", cyc, pc_data_in, e_pcd); end
      n_checks++; if (prefetch_idle !== e_idle) begin n_fail++; $display("FAIL rnd_prefetch_idle c%0d: got %0h want %0h", cyc, prefetch_idle, e_idle); end

      // Reference model: effect of this cycle's inputs on the architectural state
      fire = e_req && fetch_ack;
      resp = fetch_data_valid && m_out;
      cap  = load_imm16 && !m_immv && (m_q.size() != 0);
      popi = inst_done && e_ivalid;
      ext  = ext_pc_next && e_idle;
      if (fire) begin
        resp_addr = m_fpc;
        resp_timer = $urandom_range(1, 3);
      end
      if (write_pc) m_shadow[2*ci +: 2] = pc_data_out;
      if (cap) m_imm = m_q[0];
      else if (next_imm_data) m_imm = m_imm >> 2;
      if (cap || popi || (ext && m_q.size() != 0)) void'(m_q.pop_front());
      if (resp && !m_disc) m_q.push_back(fetch_data);
      if (flush) begin
        m_pc = m_shadow & 16'hFFFE;
        m_fpc = m_pc;
        m_q.delete();
        m_immv = 1'b0;
        m_disc = m_out && !resp;
      end else begin
        if (cap || popi || ext) m_pc = m_pc + 16'd2;
        if (fire) m_fpc = m_fpc + 16'd2;
        if (cap) m_immv = 1'b1;
        else if (inst_done) m_immv = 1'b0;
        if (resp) m_disc = 1'b0;
      end
      if (fire) m_out = 1'b1;
      else if (resp) m_out = 1'b0;
      if (wr_idx >= 0) wr_idx = (wr_idx == 7) ? -1 : wr_idx + 1;
      cycle();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_fetch_fill();
    test_imm();
    test_pc_flush();
    test_block_ext();
    test_wrap();
    test_reset_stale();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
